// File: rtl/mbc_gen_chip.sv
// Cartridge bank controller: maps CPU ROM/RAM windows to cartridge addresses.
// Optional real-time clock (MBC3-style) is built when MBC_RTC_EN is defined.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   iadr, data, write CPU address, write data, write strobe (acts on 1->0)
//   oadr              cartridge address, ROM_BANK_BITS+14 bits
//   sel_rom, sel_ram  ROM / RAM chip selects
//   sel_rtc           RTC register read select (0 without MBC_RTC_EN)
//   rtc_rdata         latched RTC register value (0 without MBC_RTC_EN)
//   rtc_tick          1 Hz single-cycle enable (ignored without MBC_RTC_EN)
module mbc_gen_chip #(
    parameter int ROM_BANK_BITS   = 8,
    parameter int RAM_BANK_BITS   = 2,
    parameter int ZERO_BANK_REMAP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              iadr,
    input  logic [7:0]               data,
    input  logic                     write,
    output logic [ROM_BANK_BITS+13:0] oadr,
    output logic                     sel_rom,
    output logic                     sel_ram,
    output logic                     sel_rtc,
    output logic [7:0]               rtc_rdata,
    input  logic                     rtc_tick
);
    localparam int AW  = ROM_BANK_BITS + 14;
    localparam int RBW = ROM_BANK_BITS;

    logic           pwrite_q;
    logic [RBW-1:0] rom_bank_q, rom_bank_d;
    logic [RBW-1:0] bank_lo, bank_hi, eff_bank;
    logic [3:0]     ram_sel_q;
    logic           ram_ena_q;
    logic           wr_ev, wr_ena, wr_lo, wr_hi, wr_sel, wr_ltc, wr_ram;
    logic           in_ram_win;

    // One event per strobe, on the cycle write is seen low after being high.
    assign wr_ev  = pwrite_q & ~write;
    assign wr_ena = wr_ev && (iadr[15:13] == 3'b000);
    assign wr_lo  = wr_ev && (iadr[15:12] == 4'h2);
    assign wr_hi  = wr_ev && (iadr[15:12] == 4'h3);
    assign wr_sel = wr_ev && (iadr[15:13] == 3'b010);
    assign wr_ltc = wr_ev && (iadr[15:13] == 3'b011);
    assign wr_ram = wr_ev && (iadr[15:13] == 3'b101);
    assign in_ram_win = (iadr[15:13] == 3'b101);

    // Low write replaces bank[7:0]; high write touches bank[8] only.
    if (ROM_BANK_BITS == 9) begin : g_b9
        assign bank_lo = {rom_bank_q[8], data};
        assign bank_hi = {data[0], rom_bank_q[7:0]};
    end else begin : g_bn
        assign bank_lo = data[RBW-1:0];
        assign bank_hi = rom_bank_q;
    end

    always_comb begin
        rom_bank_d = rom_bank_q;
        if (wr_lo)
            rom_bank_d = bank_lo;
        else if (wr_hi)
            rom_bank_d = bank_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwrite_q   <= 1'b0;
            rom_bank_q <= '0;
            ram_sel_q  <= '0;
            ram_ena_q  <= 1'b0;
        end else begin
            pwrite_q   <= write;
            rom_bank_q <= rom_bank_d;
            if (wr_ena)
                ram_ena_q <= (data[3:0] == 4'ha);
            if (wr_sel)
                ram_sel_q <= data[3:0];
        end
    end

    assign eff_bank = (ZERO_BANK_REMAP != 0 && rom_bank_q == '0)
                    ? RBW'(1) : rom_bank_q;

    always_comb begin
        oadr    = '0;
        sel_rom = 1'b0;
        sel_ram = 1'b0;
        if (!iadr[15]) begin
            sel_rom = !reset;
            oadr    = iadr[14] ? {eff_bank, iadr[13:0]}
                               : {{RBW{1'b0}}, iadr[13:0]};
        end else if (in_ram_win && !ram_sel_q[3]) begin
            sel_ram = ram_ena_q && !reset;
            oadr    = AW'({ram_sel_q[RAM_BANK_BITS-1:0], iadr[12:0]});
        end
    end

`ifdef MBC_RTC_EN
    typedef enum logic {L_IDLE, L_ARMED} lstate_t;

    lstate_t    state_q, state_d;
    logic       latch_en, rtc_wr, rtc_reg;
    logic [5:0] sec_q, sec_d, min_q, min_d, lsec_q, lmin_q;
    logic [4:0] hour_q, hour_d, lhour_q;
    logic [8:0] day_q, day_d, lday_q;
    logic       halt_q, halt_d, carry_q, carry_d, lhalt_q, lcarry_q;

    assign rtc_wr  = wr_ram && ram_ena_q;
    assign rtc_reg = (ram_sel_q >= 4'h8) && (ram_sel_q <= 4'hc);
    assign sel_rtc = !reset && ram_ena_q && in_ram_win && rtc_reg;

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        if (wr_ltc) begin
            case (state_q)
                L_IDLE:
                    if (data == 8'h00) state_d = L_ARMED;
                L_ARMED: begin
                    if (data == 8'h01) begin
                        latch_en = 1'b1;
                        state_d  = L_IDLE;
                    end else if (data != 8'h00) begin
                        state_d  = L_IDLE;
                    end
                end
                default: state_d = L_IDLE;
            endcase
        end
    end

    // Ticks compute the cascade first; a CPU write then overrides its field.
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        halt_d  = halt_q;
        carry_d = carry_q;
        if (rtc_tick && !halt_q) begin
            sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
            if (sec_q == 6'd59) begin
                min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
                if (min_q == 6'd59) begin
                    hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
                    if (hour_q == 5'd23) begin
                        day_d = day_q + 9'd1;
                        if (day_q == 9'd511) carry_d = 1'b1;
                    end
                end
            end
        end
        if (rtc_wr) begin
            case (ram_sel_q)
                4'h8: sec_d  = data[5:0];
                4'h9: min_d  = data[5:0];
                4'ha: hour_d = data[4:0];
                4'hb: day_d  = {day_d[8], data};
                4'hc: begin
                    day_d[8] = data[0];
                    halt_d   = data[6];
                    carry_d  = data[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= L_IDLE;
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            day_q    <= '0;
            halt_q   <= 1'b0;
            carry_q  <= 1'b0;
            lsec_q   <= '0;
            lmin_q   <= '0;
            lhour_q  <= '0;
            lday_q   <= '0;
            lhalt_q  <= 1'b0;
            lcarry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            halt_q  <= halt_d;
            carry_q <= carry_d;
            if (latch_en) begin
                lsec_q   <= sec_q;
                lmin_q   <= min_q;
                lhour_q  <= hour_q;
                lday_q   <= day_q;
                lhalt_q  <= halt_q;
                lcarry_q <= carry_q;
            end
        end
    end

    always_comb begin
        rtc_rdata = 8'h00;
        case (ram_sel_q)
            4'h8: rtc_rdata = {2'b00, lsec_q};
            4'h9: rtc_rdata = {2'b00, lmin_q};
            4'ha: rtc_rdata = {3'b000, lhour_q};
            4'hb: rtc_rdata = lday_q[7:0];
            4'hc: rtc_rdata = {lcarry_q, lhalt_q, 5'b0, lday_q[8]};
            default: ;
        endcase
    end
`else
    logic unused_rtc;
    assign unused_rtc = ^{rtc_tick, ram_sel_q, wr_ltc, wr_ram};
    assign sel_rtc    = 1'b0;
    assign rtc_rdata  = 8'h00;
`endif

endmodule

// File: tb/tb_mbc_gen_chip.sv
// Scoreboard bench for mbc_gen_chip (ROM_BANK_BITS=9, RAM_BANK_BITS=2, remap on).
// RTC vectors run only when MBC_RTC_EN is defined.
module tb_mbc_gen_chip;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] iadr;
    logic [7:0]  data;
    logic        write;
    logic [22:0] oadr;
    logic        sel_rom, sel_ram, sel_rtc;
    logic [7:0]  rtc_rdata;
    logic        rtc_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        srom;
        logic        sram;
        logic        srtc;
        bit          ck_adr;
        logic [22:0] adr;
        logic [7:0]  rd;
    } exp_t;

    exp_t sb[$];

    mbc_gen_chip #(
        .ROM_BANK_BITS(9),
        .RAM_BANK_BITS(2),
        .ZERO_BANK_REMAP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .iadr(iadr),
        .data(data),
        .write(write),
        .oadr(oadr),
        .sel_rom(sel_rom),
        .sel_ram(sel_ram),
        .sel_rtc(sel_rtc),
        .rtc_rdata(rtc_rdata),
        .rtc_tick(rtc_tick)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input string f,
                       input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", n, f, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge whenever a check is queued.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "sel_rom", 23'(sel_rom), 23'(e.srom));
            cmp(e.name, "sel_ram", 23'(sel_ram), 23'(e.sram));
            cmp(e.name, "sel_rtc", 23'(sel_rtc), 23'(e.srtc));
            cmp(e.name, "rtc_rdata", 23'(rtc_rdata), 23'(e.rd));
            if (e.ck_adr)
                cmp(e.name, "oadr", oadr, e.adr);
        end
    end

    task automatic rd(input string n, input logic [15:0] a,
                      input logic sr, input logic sm, input logic st,
                      input bit ck, input logic [22:0] ad,
                      input logic [7:0] r);
        exp_t e;
        int   k;
        e.name = n; e.srom = sr; e.sram = sm; e.srtc = st;
        e.ck_adr = ck; e.adr = ad; e.rd = r;
        iadr = a;
        sb.push_back(e);
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: monitor timeout, queue=%0d expected 0", n, sb.size());
            sb.delete();
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        iadr  = a;
        data  = d;
        write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        rtc_tick = 1'b1;
        @(posedge clk); #1;
        rtc_tick = 1'b0;
    endtask

    task automatic latch();
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h01);
    endtask

    task automatic rtc_rd(input string n, input logic [3:0] rs,
                          input logic [7:0] v);
        wr(16'h4000, {4'h0, rs});
        rd(n, 16'ha000, 0, 0, 1, 0, 23'h0, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; iadr = 16'h0; data = 8'h0;
        write = 1'b0; rtc_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd("rst_force", 16'h4000, 0, 0, 0, 0, 23'h0, 8'h00);
        rd("rst_ram", 16'ha000, 0, 0, 0, 0, 23'h0, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        rd("rst_bank0", 16'h4000, 1, 0, 0, 1, 23'h004000, 8'h00);
        rd("low_win", 16'h1234, 1, 0, 0, 1, 23'h001234, 8'h00);

        wr(16'h2000, 8'hff);
        wr(16'h3000, 8'h01);
        rd("bank1ff", 16'h7fff, 1, 0, 0, 1, 23'h7fffff, 8'h00);
        wr(16'h2000, 8'h00);
        rd("bank100", 16'h4000, 1, 0, 0, 1, 23'h400000, 8'h00);
        wr(16'h3000, 8'h00);
        rd("remap0", 16'h5000, 1, 0, 0, 1, 23'h005000, 8'h00);
        wr(16'h2000, 8'h1c);
        rd("bank1c", 16'h4abc, 1, 0, 0, 1, 23'h070abc, 8'h00);

        rd("ram_off", 16'ha123, 0, 0, 0, 1, 23'h000123, 8'h00);
        wr(16'h0000, 8'h0a);
        wr(16'h4000, 8'h03);
        rd("ram_b3", 16'ha123, 0, 1, 0, 1, 23'h006123, 8'h00);
        wr(16'h4000, 8'h05);
        rd("ram_wrap", 16'hbfff, 0, 1, 0, 1, 23'h003fff, 8'h00);
        rd("ram_wrap2", 16'ha123, 0, 1, 0, 1, 23'h002123, 8'h00);
        rd("gap_8000", 16'h8000, 0, 0, 0, 0, 23'h0, 8'h00);
        rd("gap_c000", 16'hc000, 0, 0, 0, 0, 23'h0, 8'h00);
        wr(16'h1fff, 8'h1b);
        rd("ram_dis", 16'ha123, 0, 0, 0, 1, 23'h002123, 8'h00);
        wr(16'h0000, 8'h3a);
        rd("ram_en2", 16'ha000, 0, 1, 0, 1, 23'h002000, 8'h00);

        // Strobe held high: bank moves only after the falling edge.
        wr(16'h2000, 8'h00);
        iadr = 16'h2000; data = 8'h05; write = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd("held_hi", 16'h4000, 1, 0, 0, 1, 23'h004000, 8'h00);
        iadr = 16'h2000; write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd("held_fall", 16'h4000, 1, 0, 0, 1, 23'h014000, 8'h00);

        // Reset during a strobe: the pending event is lost.
        iadr = 16'h2000; data = 8'h07; write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rd("rst_strobe", 16'h4000, 1, 0, 0, 1, 23'h004000, 8'h00);
        rd("rst_ramena", 16'ha000, 0, 0, 0, 1, 23'h000000, 8'h00);

`ifdef MBC_RTC_EN
        wr(16'h0000, 8'h0a);
        wr(16'h4000, 8'h08); wr(16'ha000, 8'd59);
        wr(16'h4000, 8'h09); wr(16'ha000, 8'd59);
        wr(16'h4000, 8'h0a); wr(16'ha000, 8'd23);
        wr(16'h4000, 8'h0b); wr(16'ha000, 8'hff);
        wr(16'h4000, 8'h0c); wr(16'ha000, 8'h01);
        tick();
        latch();
        rtc_rd("roll_ctl", 4'hc, 8'h80);
        rtc_rd("roll_sec", 4'h8, 8'h00);
        rtc_rd("roll_min", 4'h9, 8'h00);
        rtc_rd("roll_hr", 4'ha, 8'h00);
        rtc_rd("roll_day", 4'hb, 8'h00);

        tick();
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h02);
        wr(16'h6000, 8'h01);
        rtc_rd("no_latch", 4'h8, 8'h00);
        latch();
        rtc_rd("latch_1", 4'h8, 8'h01);
        tick();
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h01);
        rtc_rd("armed_hold", 4'h8, 8'h02);

        wr(16'h4000, 8'h0c); wr(16'ha000, 8'h40);
        repeat (10) tick();
        latch();
        rtc_rd("halt_sec", 4'h8, 8'h02);
        rtc_rd("halt_ctl", 4'hc, 8'h40);

        wr(16'h4000, 8'h0c); wr(16'ha000, 8'h00);
        wr(16'h4000, 8'h08); wr(16'ha000, 8'd63);
        wr(16'h4000, 8'h09); wr(16'ha000, 8'd5);
        tick();
        latch();
        rtc_rd("oor_sec", 4'h8, 8'h00);
        rtc_rd("oor_min", 4'h9, 8'h05);
        wr(16'h0000, 8'h00);
        rd("rtc_off", 16'ha000, 0, 0, 0, 0, 23'h0, 8'h05);
`else
        wr(16'h0000, 8'h0a);
        wr(16'h4000, 8'h08);
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h01);
        tick();
        rd("no_rtc", 16'ha000, 0, 0, 0, 0, 23'h0, 8'h00);
        wr(16'h4000, 8'h0c);
        rd("no_rtc_c", 16'hbfff, 0, 0, 0, 0, 23'h0, 8'h00);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
